// File: rtl/sdrdrum_pkg.sv
// Shared definitions for the strike detector: event field layout,
// detector state encoding and drop counter width.
package sdrdrum_pkg;

  localparam int DROP_COUNT_WIDTH = 8;
  localparam int DUR_LSB          = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLDOFF = 2'd2
  } det_state_e;

  // Peak sits directly above the duration field.
  function automatic int peak_lsb(input int dur_width);
    return dur_width;
  endfunction

endpackage

// File: rtl/strike_detector_if.sv
// AXI-Stream event channel carrying {peak, duration} strike records.
interface strike_axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/strike_event_fifo.sv
// Two-entry event buffer; a write into a full buffer succeeds only when
// the head is being read in the same cycle.
module strike_event_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic             rd_fire, wr_fire;

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = mem_q[rptr_q];

  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rd_fire  = rd_valid && rd_ready;
    wr_ready = (count_q != 2'd2) || rd_fire;
    wr_fire  = wr_valid && wr_ready;

    // When full, wptr == rptr: the slot being overwritten is the one read out now.
    if (wr_fire) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = ~wptr_q;
    end
    if (rd_fire) begin
      rptr_d = ~rptr_q;
    end

    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/strike_detector.sv
// Per-channel strike detector: threshold hysteresis, peak/duration tracking,
// re-trigger holdoff, and buffered AXI-Stream event output.
module strike_detector
  import sdrdrum_pkg::*;
#(
  parameter int MAG_WIDTH     = 24,
  parameter int DUR_WIDTH     = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [MAG_WIDTH-1:0]        cfg_threshold_on,
  input  logic [MAG_WIDTH-1:0]        cfg_threshold_off,
  input  logic [HOLDOFF_WIDTH-1:0]    cfg_holdoff,
  input  logic [MAG_WIDTH-1:0]        magnitude_tdata,
  input  logic                        magnitude_tvalid,
  strike_axis_if.master               m_axis,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count,
  output logic                        busy
);

  localparam int EVT_WIDTH = MAG_WIDTH + DUR_WIDTH;
  localparam int PEAK_LSB  = peak_lsb(DUR_WIDTH);

  det_state_e                  state_q, state_d;
  logic [MAG_WIDTH-1:0]        peak_q, peak_d;
  logic [DUR_WIDTH-1:0]        dur_q, dur_d;
  logic [HOLDOFF_WIDTH-1:0]    hcnt_q, hcnt_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;
  logic                        busy_q, busy_d;

  logic                        emit_valid;
  logic [EVT_WIDTH-1:0]        emit_data;
  logic                        emit_ready;

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    dur_d      = dur_q;
    hcnt_d     = hcnt_q;
    emit_valid = 1'b0;
    emit_data  = '0;
    emit_data[DUR_LSB  +: DUR_WIDTH] = dur_q;
    emit_data[PEAK_LSB +: MAG_WIDTH] = peak_q;

    if (magnitude_tvalid) begin
      case (state_q)
        ST_IDLE: begin
          if (magnitude_tdata >= cfg_threshold_on) begin
            state_d = ST_ATTACK;
            peak_d  = magnitude_tdata;
            dur_d   = DUR_WIDTH'(1);
          end
        end
        ST_ATTACK: begin
          // The terminating sample contributes to neither peak nor duration.
          if (magnitude_tdata < cfg_threshold_off) begin
            emit_valid = 1'b1;
            if (cfg_holdoff == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              hcnt_d  = cfg_holdoff;
            end
          end else begin
            if (magnitude_tdata > peak_q) peak_d = magnitude_tdata;
            if (dur_q != '1) dur_d = dur_q + DUR_WIDTH'(1);
          end
        end
        ST_HOLDOFF: begin
          if (hcnt_q <= HOLDOFF_WIDTH'(1)) begin
            hcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    drop_d = drop_q;
    if (emit_valid && !emit_ready && drop_q != '1) begin
      drop_d = drop_q + DROP_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      peak_q  <= '0;
      dur_q   <= '0;
      hcnt_q  <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      dur_q   <= dur_d;
      hcnt_q  <= hcnt_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  strike_event_fifo #(
    .WIDTH(EVT_WIDTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .wr_valid (emit_valid),
    .wr_data  (emit_data),
    .wr_ready (emit_ready),
    .rd_valid (m_axis.tvalid),
    .rd_data  (m_axis.tdata),
    .rd_ready (m_axis.tready)
  );

  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_strike_detector.sv
// Directed bench for strike_detector with a sample-level behavioural model
// checked every cycle, plus literal checks on key events.
module tb_strike_detector;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [23:0] thr_on = 24'd1000;
  logic [23:0] thr_off = 24'd800;
  logic [15:0] holdoff = 16'd4;
  logic [23:0] mag = '0;
  logic        mag_valid = 1'b0;
  logic        tready = 1'b1;
  logic [7:0]  drop_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  strike_axis_if #(.DATA_WIDTH(32)) axis ();
  assign axis.tready = tready;

  strike_detector #(
    .MAG_WIDTH(24), .DUR_WIDTH(8), .HOLDOFF_WIDTH(16)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .cfg_threshold_on  (thr_on),
    .cfg_threshold_off (thr_off),
    .cfg_holdoff       (holdoff),
    .magnitude_tdata   (mag),
    .magnitude_tvalid  (mag_valid),
    .m_axis            (axis),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  always #5 aclk = ~aclk;

  // Behavioural model: one update per clock edge, in sample terms.
  logic [31:0] exp_q[$];
  bit          in_strike = 0;
  int          hold_left = 0;
  int          m_peak = 0;
  int          m_dur = 0;
  int          m_drops = 0;
  bit          m_emit;
  logic [31:0] m_ev;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_strike = 0;
      hold_left = 0;
      m_peak    = 0;
      m_dur     = 0;
      m_drops   = 0;
      exp_q.delete();
    end else begin
      m_emit = 0;
      m_ev   = '0;
      if (exp_q.size() > 0 && tready) void'(exp_q.pop_front());
      if (mag_valid) begin
        if (hold_left > 0) begin
          hold_left = hold_left - 1;
        end else if (in_strike) begin
          if (int'(mag) < int'(thr_off)) begin
            m_emit    = 1;
            m_ev      = {m_peak[23:0], m_dur[7:0]};
            in_strike = 0;
            hold_left = int'(holdoff);
          end else begin
            if (int'(mag) > m_peak) m_peak = int'(mag);
            if (m_dur < 255) m_dur = m_dur + 1;
          end
        end else if (int'(mag) >= int'(thr_on)) begin
          in_strike = 1;
          m_peak    = int'(mag);
          m_dur     = 1;
        end
      end
      if (m_emit) begin
        if (exp_q.size() < 2) exp_q.push_back(m_ev);
        else if (m_drops < 255) m_drops = m_drops + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    check("model_tvalid", 64'(axis.tvalid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("model_tdata", 64'(axis.tdata), 64'(exp_q[0]));
    check("model_drop", 64'(drop_count), 64'(m_drops));
    check("model_busy", 64'(busy), 64'(in_strike || hold_left > 0));
  end

  task automatic sample(input logic [23:0] m, input logic v);
    mag       = m;
    mag_valid = v;
    @(posedge aclk);
    #1;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) sample(24'd0, 1'b1);
  endtask

  initial begin
    #1 areset = 1'b1;
    #20;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", 64'(axis.tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    #2 areset = 1'b0;
    @(posedge aclk);
    #1;

    // Single strike, tready high
    sample(24'd0, 1'b1);
    sample(24'd1200, 1'b1);
    check("t1_busy", 64'(busy), 64'd1);
    sample(24'd1500, 1'b1);
    sample(24'd1300, 1'b1);
    check("t1_pre_tvalid", 64'(axis.tvalid), 64'd0);
    sample(24'd700, 1'b1);
    check("t1_tvalid", 64'(axis.tvalid), 64'd1);
    check("t1_event", 64'(axis.tdata), 64'({24'd1500, 8'd3}));
    zeros(4);
    check("t1_idle", 64'(busy), 64'd0);

    // Holdoff swallows over-threshold samples
    sample(24'd1200, 1'b1);
    sample(24'd700, 1'b1);
    check("t2_ev1", 64'(axis.tdata), 64'({24'd1200, 8'd1}));
    for (int i = 0; i < 4; i++) sample(24'd1200, 1'b1);
    check("t2_holdoff_end", 64'(busy), 64'd0);
    sample(24'd1200, 1'b1);
    check("t2_retrig", 64'(busy), 64'd1);
    sample(24'd700, 1'b1);
    check("t2_ev2", 64'(axis.tdata), 64'({24'd1200, 8'd1}));
    zeros(4);

    // Duration saturation
    for (int i = 0; i < 300; i++) sample(24'd2000, 1'b1);
    sample(24'd0, 1'b1);
    check("t3_sat", 64'(axis.tdata), 64'({24'd2000, 8'd255}));
    zeros(4);

    // Three strikes into a stalled buffer
    tready = 1'b0;
    sample(24'd1100, 1'b1); sample(24'd700, 1'b1); zeros(4);
    sample(24'd1200, 1'b1); sample(24'd700, 1'b1); zeros(4);
    sample(24'd1300, 1'b1); sample(24'd700, 1'b1); zeros(4);
    check("t4_drop", 64'(drop_count), 64'd1);
    check("t4_head", 64'(axis.tdata), 64'({24'd1100, 8'd1}));
    tready = 1'b1;
    sample(24'd0, 1'b0);
    check("t4_second", 64'(axis.tdata), 64'({24'd1200, 8'd1}));
    check("t4_second_v", 64'(axis.tvalid), 64'd1);
    sample(24'd0, 1'b0);
    check("t4_empty", 64'(axis.tvalid), 64'd0);
    check("t4_drop_hold", 64'(drop_count), 64'd1);

    // Reset mid-attack with an event buffered
    tready = 1'b0;
    sample(24'd1500, 1'b1); sample(24'd700, 1'b1); zeros(4);
    sample(24'd1800, 1'b1); sample(24'd1900, 1'b1);
    #2 areset = 1'b1;
    #1;
    check("t6_tvalid", 64'(axis.tvalid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_drop", 64'(drop_count), 64'd0);
    #2 areset = 1'b0;
    tready = 1'b1;
    sample(24'd1600, 1'b1); sample(24'd1700, 1'b1); sample(24'd700, 1'b1);
    check("t6_fresh", 64'(axis.tdata), 64'({24'd1700, 8'd2}));
    check("t6_fresh_v", 64'(axis.tvalid), 64'd1);
    zeros(4);

    // Emit into a full buffer while it is being read
    holdoff = 16'd0;
    tready  = 1'b0;
    sample(24'd1100, 1'b1); sample(24'd700, 1'b1);
    sample(24'd1200, 1'b1); sample(24'd700, 1'b1);
    sample(24'd1300, 1'b1);
    tready = 1'b1;
    sample(24'd700, 1'b1);
    check("t5_drop", 64'(drop_count), 64'd0);
    check("t5_ev2", 64'(axis.tdata), 64'({24'd1200, 8'd1}));
    sample(24'd0, 1'b1);
    check("t5_ev3", 64'(axis.tdata), 64'({24'd1300, 8'd1}));
    sample(24'd0, 1'b1);
    check("t5_empty", 64'(axis.tvalid), 64'd0);
    zeros(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strike_detector.md
# strike_detector

Consumes the per-channel magnitude stream produced by the lock-in channel DSP and turns it into discrete stick-strike events. Applies on/off threshold hysteresis, tracks the peak magnitude and duration of each strike, enforces a re-trigger holdoff, and emits one AXI-Stream event per strike through a 2-entry buffer toward the host/PS readout path. One instance per channel, downstream of each channel's magnitude output.

## Interface
Parameters:
- MAG_WIDTH, 24, magnitude sample width (matches channel magnitude_tdata)
- DUR_WIDTH, 8, strike duration counter width, in samples
- HOLDOFF_WIDTH, 16, holdoff counter width, in samples

Ports:
- aclk  in  1  sole clock, all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- cfg_threshold_on  in  MAG_WIDTH  strike start threshold (unsigned)
- cfg_threshold_off  in  MAG_WIDTH  strike end threshold (unsigned)
- cfg_holdoff  in  HOLDOFF_WIDTH  samples ignored after a strike ends
- magnitude_tdata  in  MAG_WIDTH  unsigned magnitude sample
- magnitude_tvalid  in  1  sample strobe; no tready, every valid sample is consumed
- m_axis_tdata  out  MAG_WIDTH+DUR_WIDTH  event: [MAG_WIDTH+DUR_WIDTH-1:DUR_WIDTH] peak, [DUR_WIDTH-1:0] duration
- m_axis_tvalid  out  1  event available
- m_axis_tready  in  1  downstream accepts event
- drop_count  out  8  events lost to full buffer, saturating at 255
- busy  out  1  high when state is not IDLE

## Operation
- State machine IDLE / ATTACK / HOLDOFF; advances only on cycles with magnitude_tvalid=1.
- IDLE: sample >= cfg_threshold_on -> ATTACK, peak <= sample, dur <= 1.
- ATTACK: sample < cfg_threshold_off -> emit {peak, dur}; go HOLDOFF with hcnt <= cfg_holdoff, or directly IDLE if cfg_holdoff == 0. Terminating sample is not counted in dur nor peak. Otherwise peak <= max(peak, sample), dur <= dur+1 saturating at 2^DUR_WIDTH-1.
- HOLDOFF: each valid sample decrements hcnt; when hcnt reaches 0 (decrement from 1) -> IDLE. Samples in HOLDOFF never start a strike, even if >= threshold_on.
- Comparisons unsigned, full width. Config is sampled every valid sample; changing it outside IDLE is legal, takes effect on next sample.
- Output buffer: 2-entry FIFO. Emit when full and no read this cycle -> event dropped, drop_count increments (saturating). Emit while full with simultaneous read (tvalid & tready) -> write succeeds.
- drop_count clears only on areset.

## Timing
- Reset (async assert, sync-safe deassert by integrator): state IDLE, peak 0, dur 0, hcnt 0, FIFO empty, m_axis_tvalid 0, m_axis_tdata 0, drop_count 0, busy 0.
- Emit latency: terminating sample sampled at edge k; m_axis_tvalid high from cycle after edge k (1 cycle), tdata registered.
- AXIS rules: tvalid never deasserts and tdata never changes until tready sampled high; tvalid not dependent on tready.
- Back-to-back reads: FIFO delivers one event per cycle while non-empty and tready=1.
- busy is registered from state, valid the cycle after transition.
- Reset mid-strike or mid-holdoff: in-progress strike and buffered events discarded, no partial event emitted.

## Structure
- Shared package sdrdrum_pkg: event field offsets (peak/duration positions), state encoding enum for IDLE/ATTACK/HOLDOFF, DROP_COUNT_WIDTH=8.
- One sub-module: strike_event_fifo (2-entry, AXIS write-with-full / read handshake, simultaneous read+write when full). Detector FSM stays in top.

## Test plan
- on=1000, off=800, holdoff=4; samples 0,1200,1500,1300,700 -> one event peak=1500, dur=3, tvalid one cycle after the 700 sample, tready=1.
- Same thresholds; samples 1200,700,1200,1200,1200,1200,1200,700 -> first event {1200,1}; holdoff swallows next four 1200s; fifth 1200 starts ATTACK, second event {1200,1}.
- Strike of 300 samples at 2000 then 0 -> duration saturates at 255, peak=2000.
- tready=0, three complete strikes -> two events held, drop_count=1; raise tready -> two events delivered in order on consecutive cycles, tvalid then 0.
- FIFO full, tready=1 on same cycle as third emit -> no drop, drop_count=0, three events delivered.
- areset pulsed mid-ATTACK with one event buffered -> tvalid 0, busy 0, drop_count 0 immediately; next strike yields fresh event with correct peak/dur.
